// File: rtl/fifo_stream_reader.sv
// Drains a standard (non-FWFT) synchronous FIFO into a valid/ready stream,
// hiding the one-cycle read latency behind a 2-entry skid buffer and framing packets.
module fifo_stream_reader #(
   parameter int DATA_W  = 32,
   parameter int PKT_LEN = 256
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   input  logic              fifo_rd_rst_busy,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic [15:0]       beat_cnt
);

   localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

   logic [DATA_W-1:0] buf0;
   logic [DATA_W-1:0] buf1;
   logic [DATA_W-1:0] buf0_nxt;
   logic [DATA_W-1:0] buf1_nxt;
   logic [1:0]        buf_cnt;
   logic [1:0]        buf_cnt_nxt;
   logic              inflight;
   logic              pop;
   logic [2:0]        occupancy;

   assign pop = m_valid & m_ready;

   // Counting the word leaving this cycle lets a read overlap a pop, which is what keeps 1 beat/cycle.
   assign occupancy  = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = !srst & en & !fifo_empty & !fifo_rd_rst_busy & (occupancy < 3'd2);

   assign m_valid = (buf_cnt != 2'd0);
   assign m_data  = buf0;
   assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

   // A word captured during a pop drops into whichever slot is head-or-tail after the shift.
   always_comb begin
      buf0_nxt    = buf0;
      buf1_nxt    = buf1;
      buf_cnt_nxt = buf_cnt;
      case ({pop, inflight})
         2'b10: begin
            buf0_nxt    = buf1;
            buf_cnt_nxt = buf_cnt - 2'd1;
         end
         2'b01: begin
            if (buf_cnt == 2'd0) begin
               buf0_nxt = fifo_dout;
            end else begin
               buf1_nxt = fifo_dout;
            end
            buf_cnt_nxt = buf_cnt + 2'd1;
         end
         2'b11: begin
            if (buf_cnt == 2'd1) begin
               buf0_nxt = fifo_dout;
            end else begin
               buf0_nxt = buf1;
               buf1_nxt = fifo_dout;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         buf0     <= '0;
         buf1     <= '0;
         buf_cnt  <= 2'd0;
         inflight <= 1'b0;
      end else begin
         buf0     <= buf0_nxt;
         buf1     <= buf1_nxt;
         buf_cnt  <= buf_cnt_nxt;
         inflight <= fifo_rd_en;
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         beat_cnt <= 16'd0;
      end else if (pop) begin
         if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= 16'd0;
         end else begin
            beat_cnt <= beat_cnt + 16'd1;
         end
      end
   end

endmodule
